// File: rtl/sar_ctrl.sv
// Successive-approximation sequencer for a binary-weighted CDAC: sample, then MSB-to-LSB trials.
// Optional continuous conversion loop (CONT input) is enabled by defining SAR_CTRL_CONT_EN.
module sar_ctrl #(
    parameter int NBIT       = 5,
    parameter int SAMPLE_CYC = 4,
    parameter int SETTLE_CYC = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
`ifdef SAR_CTRL_CONT_EN
    input  logic            cont,
`endif
    input  logic            cmp,
    output logic            sample,
    output logic            cmp_en,
    output logic [NBIT-1:0] cb,
    output logic            busy,
    output logic            done,
    output logic [NBIT-1:0] dout
);

    localparam int PW = (NBIT > 1) ? $clog2(NBIT) : 1;

    typedef enum logic [2:0] {IDLE, SAMP, SETTLE, STROBE, DECIDE, FIN} state_t;

    localparam logic [7:0]    SAMP_LAST   = 8'(SAMPLE_CYC - 1);
    localparam logic [7:0]    SETTLE_LAST = 8'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
    localparam logic [PW-1:0] PTR_TOP     = PW'(NBIT - 1);
    localparam logic [PW-1:0] PTR_ONE     = PW'(1);
    // With no settle time each bit starts directly at the comparator strobe.
    localparam state_t        BIT_ENTRY   = (SETTLE_CYC == 0) ? STROBE : SETTLE;

    state_t          state, state_nxt;
    logic [PW-1:0]   ptr, ptr_nxt;
    logic [7:0]      cnt, cnt_nxt;
    logic [NBIT-1:0] res, res_nxt;
    logic            loop_en;

    logic            sample_nxt, cmp_en_nxt, busy_nxt, done_nxt;
    logic [NBIT-1:0] cb_nxt, dout_nxt;

`ifdef SAR_CTRL_CONT_EN
    assign loop_en = cont;
`else
    assign loop_en = 1'b0;
`endif

    function automatic logic [NBIT-1:0] trial_code(input logic [NBIT-1:0] r,
                                                   input logic [PW-1:0]   p);
        logic [NBIT-1:0] one_hot;
        one_hot    = '0;
        one_hot[0] = 1'b1;
        return r | (one_hot << p);
    endfunction

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sample <= 1'b0;
            cmp_en <= 1'b0;
            cb     <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            dout   <= '0;
        end else begin
            state  <= state_nxt;
            sample <= sample_nxt;
            cmp_en <= cmp_en_nxt;
            cb     <= cb_nxt;
            busy   <= busy_nxt;
            done   <= done_nxt;
            dout   <= dout_nxt;
        end
    end

    always_ff @(posedge clk) begin
        ptr <= ptr_nxt;
        cnt <= cnt_nxt;
        res <= res_nxt;
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        res_nxt   = res;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_nxt = SAMP;
                        cnt_nxt   = '0;
                        res_nxt   = '0;
                    end
                end
                SAMP: begin
                    if (cnt == SAMP_LAST) begin
                        state_nxt = BIT_ENTRY;
                        cnt_nxt   = '0;
                        ptr_nxt   = PTR_TOP;
                    end else begin
                        cnt_nxt = cnt + 8'd1;
                    end
                end
                SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        state_nxt = STROBE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 8'd1;
                    end
                end
                STROBE: state_nxt = DECIDE;
                DECIDE: begin
                    // res[ptr] is still clear here, so rejecting the trial just keeps res.
                    res_nxt = cmp ? res : trial_code(res, ptr);
                    if (ptr == '0) begin
                        state_nxt = FIN;
                    end else begin
                        ptr_nxt   = ptr - PTR_ONE;
                        state_nxt = BIT_ENTRY;
                    end
                end
                FIN: begin
                    if (loop_en) begin
                        state_nxt = SAMP;
                        cnt_nxt   = '0;
                        res_nxt   = '0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Outputs are decoded from the upcoming state so they can be registered without latency.
    always_comb begin
        sample_nxt = 1'b0;
        cmp_en_nxt = 1'b0;
        cb_nxt     = '0;
        done_nxt   = 1'b0;
        busy_nxt   = (state_nxt != IDLE);
        dout_nxt   = dout;
        case (state_nxt)
            SAMP:   sample_nxt = 1'b1;
            SETTLE: cb_nxt = trial_code(res_nxt, ptr_nxt);
            STROBE: begin
                cb_nxt     = trial_code(res_nxt, ptr_nxt);
                cmp_en_nxt = 1'b1;
            end
            DECIDE: cb_nxt = trial_code(res_nxt, ptr_nxt);
            FIN: begin
                cb_nxt   = res_nxt;
                dout_nxt = res_nxt;
                done_nxt = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/sar_ctrl.md
# sar_ctrl

Successive-approximation sequencer for the 5-bit binary-weighted CDAC array. It runs one conversion per START: a sampling phase with the top plate connected, then a trial sequence from MSB to LSB. For each bit it drives the CDAC bottom-plate code CB[4:0], waits for the array to settle, strobes the comparator, and keeps or clears the trial bit. It sits between the ADC digital front end and the CDAC/comparator macro pair.

## Interface
- NBIT, 5: resolution; must match CDAC CB width.
- SAMPLE_CYC, 4: cycles SAMPLE is held high; legal range 1..255.
- SETTLE_CYC, 2: CDAC settle cycles per bit before the strobe; legal range 0..255.
- CLK  in  1  conversion clock.
- RST_N  in  1  reset; asynchronous and active-low.
- START  in  1  one-cycle conversion request; ignored while BUSY=1.
- ABORT  in  1  synchronous abort; returns the block to IDLE.
- CMP  in  1  comparator decision; 1 means CT is above threshold, so the trial is too large.
- SAMPLE  out  1  top-plate sampling switch enable.
- CMP_EN  out  1  comparator strobe.
- CB  out  NBIT  trial code to CDAC CB[4:0]; CDAC inverts it internally.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle completion pulse.
- DOUT  out  NBIT  last conversion result; held until the next DONE.

## Operation
- States:
  - IDLE, SAMP, SETTLE, STROBE, DECIDE, FIN.
  - bit index ptr runs NBIT-1 down to 0.
  - result register res.
  - 8-bit cycle counter cnt.
- IDLE:
  - SAMPLE=0, CMP_EN=0, CB=0.
  - START=1 → SAMP, with cnt=0, res=0.
- SAMP:
  - SAMPLE=1, CB=0.
  - After SAMPLE_CYC cycles → SETTLE with ptr=NBIT-1.
- SETTLE:
  - CB = res | (1<<ptr).
  - Held for SETTLE_CYC cycles → STROBE.
  - If SETTLE_CYC=0, the state is skipped and SAMP/DECIDE go directly to STROBE.
- STROBE:
  - CB unchanged, CMP_EN=1 for exactly one cycle.
  - Next state is DECIDE.
- DECIDE:
  - CB unchanged, CMP_EN=0.
  - CMP is sampled at the rising edge ending this cycle.
  - If CMP=0, res[ptr]=1; otherwise res[ptr]=0.
  - If ptr=0 → FIN; else ptr decrements → SETTLE.
- FIN:
  - CB = res, DOUT = res, DONE=1 for one cycle.
  - Next state is IDLE, or SAMP in continuous mode.
- START while BUSY=1: ignored, not queued.
- ABORT=1 in any state:
  - Next cycle is IDLE with CB=0, SAMPLE=0.
  - No DONE, DOUT unchanged.
  - ABORT takes priority over START in the same cycle.
- CMP is ignored outside DECIDE.
- DOUT changes only in FIN.

## Timing
- Reset values: SAMPLE=0, CMP_EN=0, CB=0, BUSY=0, DONE=0, DOUT=0, state IDLE.
  - Reset asserted mid-conversion forces these values immediately, without waiting for a clock edge.
- All outputs are registered; there is no combinational path from an input to an output.
- Cycle numbering: START sampled high at edge 0. Defaults apply (SAMPLE_CYC=4, SETTLE_CYC=2).
  - SAMPLE high in cycles 1–4.
  - Bit 4 occupies cycles 5–8 (SETTLE 5–6, STROBE 7, DECIDE 8).
  - Bits 3, 2, 1, 0 occupy cycles 9–12, 13–16, 17–20, 21–24.
  - FIN (DONE=1, DOUT valid) in cycle 25.
  - Generic conversion length: SAMPLE_CYC + NBIT*(SETTLE_CYC+2) + 1 cycles.
- The earliest accepted next START is the cycle after FIN.
- BUSY rises the cycle after START is accepted and falls when IDLE is re-entered.

## Configuration
- SAR_CTRL_CONT_EN defined:
  - Adds input port CONT (1 bit).
  - In FIN, if CONT=1 the block goes directly to SAMP with no IDLE cycle; BUSY stays high and DONE still pulses each conversion.
  - CONT=0 or ABORT=1 ends the loop.
- SAR_CTRL_CONT_EN undefined:
  - No CONT port.
  - FIN always goes to IDLE, and each conversion needs its own START.

## Test plan
- Reset check: hold RST_N low, toggle START/CMP → all outputs stay 0. Release RST_N, pulse START → SAMPLE high in cycles 1–4.
- Comparator model, input code 10110 (CMP=1 when CB > 10110): CB trials are 10000, 11000, 10100, 10110, 10111. DONE pulses at cycle 25 with DOUT=10110.
- CMP stuck at 1 → DOUT=00000. CMP stuck at 0 → DOUT=11111. CMP_EN pulses exactly 5 times per conversion, once in each of cycles 7/11/15/19/23.
- START held high throughout → only one conversion until FIN. ABORT in cycle 14 → IDLE in cycle 15, no DONE, DOUT keeps the previous value.
- SETTLE_CYC=0, SAMPLE_CYC=1 → DONE at cycle 12. RST_N dropped at cycle 10 → CB=0 and BUSY=0 without waiting for a clock edge.
- SAR_CTRL_CONT_EN with CONT=1 → DONE every 25 cycles and SAMPLE re-asserts the cycle after FIN. Clearing CONT → IDLE after the current FIN.
